// File: rtl/p18_spi_rx.sv
// p18_spi_rx: SPI mode-0 slave receiver. Oversamples sck/mosi/cs_n in the clk
// domain and deserialises MOSI into 16-bit words for the P18 command controller.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on sck, mosi, cs_n (2..3)
//   MSB_FIRST    1: first bit lands in word[15]; 0: first bit lands in word[0]
// Ports:
//   clk, nRst     system clock, asynchronous active-low reset
//   sck, mosi     SPI clock (CPOL=0) and data in, asynchronous to clk
//   cs_n          SPI chip select, active-low, asynchronous to clk
//   miso          SPI data out (echo of previous word) when P18_SPI_MISO_EN is defined, else 0
//   start         one-cycle pulse at frame open
//   word_en       one-cycle pulse when a 16-bit word completes
//   word          last completed word, held between word_en pulses
//   frame_active  high while a frame is open
// Optional feature macro: P18_SPI_MISO_EN (builds the transmit shift register).

module p18_spi_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        sck,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        miso,
    output logic        start,
    output logic        word_en,
    output logic [15:0] word,
    output logic        frame_active
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronisers, previous-value registers and chain-filled tracker
    logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] vld_q,       vld_d;
    logic                   sck_prev_q,  sck_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic                   armed_q,     armed_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [WORD_W-1:0]      word_q,  word_d;
    logic                   start_q, start_d;
    logic                   word_en_q, word_en_d;
    logic                   frame_active_q, frame_active_d;

    logic sck_s, mosi_s, cs_s, vld_s;
    logic rise, fall, cs_fall, cs_rise;
    logic sample_bit;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign vld_s  = vld_q[SYNC_STAGES-1];

    assign rise    = sck_s & ~sck_prev_q;
    assign fall    = ~sck_s & sck_prev_q;
    // The cs chain resets to 1, so a cs_n already low at reset release would look
    // like a fall; only accept falls once a genuine high level has been sampled.
    assign cs_fall = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise = ~cs_prev_q & cs_s;

    // Synchroniser shift and edge-detect history
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        vld_d       = {vld_q[SYNC_STAGES-2:0],       1'b1};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        armed_d     = armed_q | (vld_s & cs_s);
    end

    // Frame FSM, bit counter, shift register and word output
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        start_d    = 1'b0;
        word_en_d  = 1'b0;
        sample_bit = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    start_d    = 1'b1;
                    sample_bit = rise;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // Partial word dropped; a coincident sck rise is ignored
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    sample_bit = rise;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // cnt_q is always 0 in IDLE, so the frame-opening bit counts from 0
        if (sample_bit) begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[WORD_W-2:0], mosi_s};
            end else begin
                shift_d = {mosi_s, shift_q[WORD_W-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
                word_en_d = 1'b1;
                word_d    = shift_d;
            end
        end

        frame_active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sck_sync_q     <= '0;
            mosi_sync_q    <= '0;
            cs_sync_q      <= '1;
            vld_q          <= '0;
            sck_prev_q     <= 1'b0;
            cs_prev_q      <= 1'b1;
            armed_q        <= 1'b0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            word_q         <= '0;
            start_q        <= 1'b0;
            word_en_q      <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            sck_sync_q     <= sck_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            cs_sync_q      <= cs_sync_d;
            vld_q          <= vld_d;
            sck_prev_q     <= sck_prev_d;
            cs_prev_q      <= cs_prev_d;
            armed_q        <= armed_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            word_q         <= word_d;
            start_q        <= start_d;
            word_en_q      <= word_en_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign start        = start_q;
    assign word_en      = word_en_q;
    assign word         = word_q;
    assign frame_active = frame_active_q;

`ifdef P18_SPI_MISO_EN
    logic [WORD_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;

    // Transmit register: echoes the last completed word, shifted out on sck falls
    always_comb begin
        tx_d = tx_q;
        if ((state_q == ACTIVE) && fall) begin
            if (MSB_FIRST) begin
                tx_d = {tx_q[WORD_W-2:0], 1'b0};
            end else begin
                tx_d = {1'b0, tx_q[WORD_W-1:1]};
            end
        end
        if (cs_fall || word_en_q) begin
            tx_d = word_q;
        end
        if (state_d == ACTIVE) begin
            miso_d = MSB_FIRST ? tx_d[WORD_W-1] : tx_d[0];
        end else begin
            miso_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            miso_q <= miso_d;
        end
    end

    assign miso = miso_q;
`else
    logic unused_fall;
    assign unused_fall = fall;
    assign miso        = 1'b0;
`endif

endmodule
